demux4_router: RTL
==================

Name: demux4_router

Overview:
- 1-to-4 routing demultiplexer; the distributing counterpart of the datapath 4:1 result mux.
- Takes one DATA_W-bit word plus a 2-bit select on a valid/ready input and delivers it to one of four registered output channels. Each output channel has its own valid/ready handshake.
- Sits between a producer (ALU/writeback result) and up to four consumers. Each consumer may stall independently without blocking traffic to the others.
- Per-channel delivery counters support debug and verification.

Parameters:
DATA_W, 32, width of routed data word
CNT_W, 8, width of each per-channel delivery counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  router accepts word this cycle
in_sel  input  2  destination channel 0..3
in_data  input  DATA_W  word to route
out_valid  output  4  bit k: channel k holds a word
out_ready  input  4  bit k: consumer k takes the word this cycle
out_data0  output  DATA_W  channel 0 data
out_data1  output  DATA_W  channel 1 data
out_data2  output  DATA_W  channel 2 data
out_data3  output  DATA_W  channel 3 data
cnt_clr  input  1  synchronous clear of all counters
cnt0..cnt3  output  CNT_W each  deliveries completed on channel k

Behaviour:
- Reset (rst_n=0, asynchronous, any time): all out_valid=0, out_data0..3=0, cnt0..3=0. Words held or in flight are discarded. Outputs hold reset values until the first rising clk edge after rst_n=1.
- Channel storage: one holding register per channel, holding data_k and valid_k.
- Drain k: out_valid[k] & out_ready[k] at a clock edge.
- Accept: in_valid & in_ready at a clock edge.
- in_ready (combinational) = !valid[in_sel] | out_ready[in_sel]. A full slot can be refilled in the same cycle it drains, so each channel sustains 1 word/cycle.
- in_ready depends only on the selected channel. A stalled channel never blocks words to other channels.
- Accept: data_[in_sel] <= in_data; valid[in_sel] <= 1. out_valid rises on the cycle after acceptance (latency 1).
- Drain without accept on the same channel: valid_k <= 0. data_k keeps its last value; it is don't-care while out_valid[k]=0.
- Drain and accept on the same channel in the same cycle: new word loaded, valid_k stays 1.
- While out_valid[k]=1 and out_ready[k]=0, out_data_k is stable.
- in_valid=1 with in_ready=0: producer must hold in_data and in_sel stable until accepted. A bench assertion checks this. The router does not latch the request.
- out_valid never depends combinationally on out_ready.
- out_ready asserted while out_valid=0 has no effect.
- Counters: cnt_k increments by 1 on every drain k. It wraps from 2^CNT_W-1 to 0 with no saturation or flag.
- cnt_clr=1: all counters become 0 at the edge. This takes priority over a simultaneous increment, so the result is 0.
- Multiple channels may drain in the same cycle; each counter updates independently.
- No FSM beyond the per-channel valid bit. Each channel is in exactly one of two states: EMPTY or FULL.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain+accept or on stall.

Test Plan:
- Reset then idle. Drive rst_n low mid-stream with ch2 FULL. Required: out_valid=0000, out_data*=0, cnt*=0 immediately (async), in_ready=1 for every in_sel once rst_n=1.
- Single route: in_sel=2, in_data=0xDEADBEEF, out_ready=0000. Required:
  - out_valid=0100 next cycle, out_data2=0xDEADBEEF.
  - After out_ready[2]=1 for one cycle: out_valid=0000, cnt2=1.
- Back-pressure isolation: ch1 FULL with out_ready[1]=0.
  - in_sel=1 -> in_ready=0, word held stable.
  - Switching the stream to in_sel=3 with 0x00000033 -> in_ready=1, out_valid[3] set next cycle; ch1 data unchanged.
- Full throughput: out_ready=1111, 8 consecutive words 0x10..0x17 to ch0. Required:
  - in_ready=1 every cycle.
  - out_data0 shows each word exactly one cycle after acceptance.
  - cnt0=8.
- Counter wrap and clear with CNT_W=8:
  - 256 drains on ch3 -> cnt3=0.
  - 5 more drains -> cnt3=5.
  - cnt_clr=1 in the same cycle as a drain -> cnt3=0.

Source files
------------

// File: rtl/demux4_router.sv
// demux4_router: routes one valid/ready input word to one of four registered
// output channels. Each channel has its own independent valid/ready handshake
// and a wrapping delivery counter.
module demux4_router #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
);

    // Delivery counters wrap silently; no saturation or overflow flag.
    function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    // Holding registers: one data word and one valid bit per channel.
    logic [DATA_W-1:0] data_p1 [4];
    logic [3:0]        vld_p1;
    logic [CNT_W-1:0]  cnt_p1  [4];

    // Decoded per-channel accept and drain strobes for this cycle.
    logic [3:0] acc_p0;
    logic [3:0] drain_p0;
    logic       fire_p0;

    // ---- stage p0: handshake decode (combinational) ----

    // Ready depends only on the selected slot; a full slot that drains this
    // cycle can be refilled, giving 1 word/cycle per channel.
    always_comb begin
        in_ready = !vld_p1[in_sel] || out_ready[in_sel];
        fire_p0  = in_valid && in_ready;
        acc_p0   = 4'b0000;
        if (fire_p0) begin
            acc_p0[in_sel] = 1'b1;
        end
        drain_p0 = vld_p1 & out_ready;
    end

    // ---- stage p1: channel holding registers ----

    // Load on accept (accept wins over drain so valid stays high); clear valid
    // on a drain without refill. Data is left alone when a slot empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc_p0[k]) begin
                    data_p1[k] <= in_data;
                    vld_p1[k]  <= 1'b1;
                end else if (drain_p0[k]) begin
                    vld_p1[k]  <= 1'b0;
                end
            end
        end
    end

    // Count completed deliveries per channel; a clear overrides any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (cnt_clr) begin
                    cnt_p1[k] <= '0;
                end else if (drain_p0[k]) begin
                    cnt_p1[k] <= cnt_wrap_inc(cnt_p1[k]);
                end
            end
        end
    end

    // ---- outputs: straight from the p1 registers ----

    assign out_valid = vld_p1;
    assign out_data0 = data_p1[0];
    assign out_data1 = data_p1[1];
    assign out_data2 = data_p1[2];
    assign out_data3 = data_p1[3];
    assign cnt0      = cnt_p1[0];
    assign cnt1      = cnt_p1[1];
    assign cnt2      = cnt_p1[2];
    assign cnt3      = cnt_p1[3];

endmodule
